// File: rtl/mux.sv
// mux: two-input, one-select multiplexer with a registered copy, a valid flag and an
// optional saturating select-change counter (built only when MUX_SEL_CNT_EN is defined).
module mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic             c_vld,
  output logic [CNT_W-1:0] sel_chg_cnt
);

  // An unknown select yields an all-X output rather than silently favouring either input
  always_comb begin
    c = 'x;
    case (s)
      1'b0:    c = a;
      1'b1:    c = b;
      default: c = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q   <= '0;
      c_vld <= 1'b0;
    end else if (en) begin
      c_q   <= c;
      c_vld <= 1'b1;
    end
  end

`ifdef MUX_SEL_CNT_EN
  logic s_prev;

  // Counts edges where s differs from its value at the previous edge; sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev      <= 1'b0;
      sel_chg_cnt <= '0;
    end else begin
      s_prev <= s;
      if ((s != s_prev) && (sel_chg_cnt != {CNT_W{1'b1}}))
        sel_chg_cnt <= sel_chg_cnt + 1'b1;
    end
  end
`else
  assign sel_chg_cnt = '0;
`endif

endmodule

// File: tb/tb_mux.sv
// tb_mux: randomized and directed checks of mux against a behavioural model of the
// select rule, the enabled capture, and the saturating select-change count.
module tb_mux;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clk_run = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b;
  logic             s, en;
  logic [WIDTH-1:0] c, c_q;
  logic             c_vld;
  logic [CNT_W-1:0] sel_chg_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: what the registered side should hold after each edge
  logic [WIDTH-1:0] model_q;
  logic             model_vld;
  int               model_prev;
  int               model_changes;

  mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .en(en),
    .c(c), .c_q(c_q), .c_vld(c_vld), .sel_chg_cnt(sel_chg_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                               input logic ns, input logic nen);
    a  = na;
    b  = nb;
    s  = ns;
    en = nen;
  endtask

  function automatic logic [WIDTH-1:0] selected(input logic [WIDTH-1:0] xa,
                                                input logic [WIDTH-1:0] xb, input logic xs);
    return xs ? xb : xa;
  endfunction

  function automatic int expectedCount();
`ifdef MUX_SEL_CNT_EN
    return (model_changes > CNT_MAX) ? CNT_MAX : model_changes;
`else
    return 0;
`endif
  endfunction

  task automatic resetModel();
    model_q       = '0;
    model_vld     = 1'b0;
    model_prev    = 0;
    model_changes = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven
  task automatic clockEdge();
    @(posedge clk);
    if (en) begin
      model_q   = selected(a, b, s);
      model_vld = 1'b1;
    end
    if (int'(s) != model_prev) model_changes++;
    model_prev = int'(s);
    #1;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_c_q"}, 32'(c_q), 32'(model_q));
    checkOutput({tag, "_vld"}, 32'(c_vld), 32'(model_vld));
    checkOutput({tag, "_cnt"}, 32'(sel_chg_cnt), 32'(expectedCount()));
  endtask

  initial begin
    logic [2:0] pattern;
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    resetModel();
    #3;
    checkRegs("reset");

    // Truth table with the clock stopped and reset held: c must still follow a/b/s
    for (int i = 0; i < 8; i++) begin
      pattern = 3'(i);
      applyStimulus({WIDTH{pattern[2]}}, {WIDTH{pattern[1]}}, pattern[0], 1'b0);
      #1;
      checkOutput($sformatf("truth_%0d", i), 32'(c),
                  32'({WIDTH{pattern[0] ? pattern[1] : pattern[2]}}));
    end
    applyStimulus('1, '0, 1'b0, 1'b1);
    #1;
    checkOutput("rst_comb_s0", 32'(c), 32'({WIDTH{1'b1}}));
    s = 1'b1;
    #1;
    checkOutput("rst_comb_s1", 32'(c), 32'(0));
    checkRegs("rst_held");

    // Registered path: capture with en, then hold with en low
    rst = 1'b0;
    applyStimulus('1, '0, 1'b1, 1'b1);
    #1;
    clk_run = 1'b1;
    clockEdge();
    checkRegs("capture");
    @(negedge clk);
    applyStimulus('0, '1, 1'b1, 1'b0);
    #1;
    checkOutput("hold_comb", 32'(c), 32'({WIDTH{1'b1}}));
    clockEdge();
    checkRegs("hold");

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      #1;
      checkOutput("rand_c", 32'(c), 32'(selected(a, b, s)));
      clockEdge();
      checkRegs("rand");
    end

    // Asynchronous reset between edges clears the registered side at once
    @(negedge clk);
    applyStimulus('1, '0, 1'b0, 1'b1);
    clockEdge();
    checkOutput("pre_rst_c_q", 32'(c_q), 32'({WIDTH{1'b1}}));
    #1;
    rst = 1'b1;
    resetModel();
    #1;
    checkRegs("async_rst");
    rst = 1'b0;

    // Consecutive select toggles from a freshly reset s_prev of 0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'((i + 1) % 2), 1'b1);
      clockEdge();
      checkRegs($sformatf("toggle_%0d", i));
    end
`ifdef MUX_SEL_CNT_EN
    checkOutput("saturated", 32'(sel_chg_cnt), 32'(CNT_MAX));
`else
    checkOutput("cnt_tied", 32'(sel_chg_cnt), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux.md
# mux

Two-input, one-select multiplexer with a combinational output and a registered copy of that output. It is the basic data-steering primitive used wherever one of two equal-width sources must be forwarded under a single select bit. A clocked side-path provides a registered output, a valid flag and an optional select-activity counter for downstream timing closure and debug.

## Interface
- WIDTH, 1, data width of a, b, c, c_q
- CNT_W, 8, width of the select-change counter
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- a  input  WIDTH  data input selected when s=0
- b  input  WIDTH  data input selected when s=1
- s  input  1  select
- en  input  1  capture enable for the registered path
- c  output  WIDTH  combinational mux output
- c_q  output  WIDTH  registered mux output
- c_vld  output  1  c_q holds a captured value
- sel_chg_cnt  output  CNT_W  saturating count of sampled select changes

## Operation
- c = a when s=0; c = b when s=1; purely combinational, independent of clk, rst and en.
- s unknown (X/Z): c drives all-X. No hidden priority between a and b.
- Registered path: on a rising clk with en=1, c_q <= c (same select rule) and c_vld <= 1. With en=0, c_q and c_vld hold.
- Select tracking: s_prev register samples s on every rising clk, regardless of en.
- sel_chg_cnt increments by 1 on each rising clk where s != s_prev. It saturates at 2^CNT_W-1 and never wraps.
- No state machine. State consists only of c_q, c_vld, s_prev and the counter.
- Bit-wise selection applies to all WIDTH bits identically. No arithmetic is performed on data.

## Timing
- c: zero-cycle latency. Settles within the same time step as any change on a, b or s.
- c_q: one-cycle latency from an enabled clk edge.
- Reset values (asserted asynchronously, without waiting for clk): c_q=0, c_vld=0, s_prev=0, sel_chg_cnt=0.
- rst has no effect on c.
- Reset release: the first edge after rst deasserts behaves as a normal edge. If s=1 at that edge, it counts as a change, since s_prev was reset to 0.
- rst asserted mid-operation clears all registered state immediately. Any capture pending in the same cycle is discarded.
- Simultaneous en=1 and an s change at the same edge: c_q takes the value selected by the new s. The counter increments on the same edge.

## Configuration
- MUX_SEL_CNT_EN defined: s_prev and the saturating sel_chg_cnt are implemented as specified.
- MUX_SEL_CNT_EN undefined: no counter or s_prev logic. sel_chg_cnt is tied to 0. All other behaviour is unchanged.

## Test plan
- Exhaustive truth table, WIDTH=1, 1 time unit after each input change. (a,b,s) = (0,0,0)->c=0, (0,0,1)->0, (0,1,0)->0, (0,1,1)->1, (1,0,0)->1, (1,0,1)->0, (1,1,0)->1, (1,1,1)->1.
- Combinational independence: hold rst=1 with clk stopped, apply a=1,b=0,s=0 -> c=1, then s=1 -> c=0. Throughout, c_q=0 and c_vld=0.
- Registered path: rst released, a=1,b=0,s=1, en=1, one clk edge -> c_q=0, c_vld=1. Then a=0,b=1, en=0, one edge -> c_q holds 0.
- Async reset: with c_q=1 and c_vld=1, pulse rst between clock edges -> c_q=0, c_vld=0, sel_chg_cnt=0 immediately.
- Counter saturation, CNT_W=2, macro defined: toggle s on 5 consecutive edges -> sel_chg_cnt reads 1,2,3,3,3.
- Macro undefined: toggle s on 4 edges -> sel_chg_cnt stays 0, and c and c_q still follow the select rule.
